// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU register-bus constants and the OAM DMA state type
package ppu_pkg;

    localparam logic [2:0] PPU_PPUCTRL   = 3'h0;
    localparam logic [2:0] PPU_PPUMASK   = 3'h1;
    localparam logic [2:0] PPU_PPUSTATUS = 3'h2;
    localparam logic [2:0] PPU_OAMADDR   = 3'h3;
    localparam logic [2:0] PPU_OAMDATA   = 3'h4;
    localparam logic [2:0] PPU_PPUSCROLL = 3'h5;
    localparam logic [2:0] PPU_PPUADDR   = 3'h6;
    localparam logic [2:0] PPU_PPUDATA   = 3'h7;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - $4014 OAM DMA: copies one CPU page into PPU OAMDATA
module oam_dma_engine
    import ppu_pkg::*;
#(
    parameter logic [2:0] OAMDATA_REG = PPU_OAMDATA,
    parameter int         NUM_BYTES   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic        cpu_odd,
    input  logic        reg_wr,
    input  logic [7:0]  reg_data,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data_in,
    output logic        ppu_cs_n,
    output logic [2:0]  ppu_address,
    output logic        ppu_rw,
    output logic [7:0]  ppu_data_out,
    output logic        dma_active,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    dma_state_t  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  latch_q, latch_d;
    logic        done_d;
    logic        active_d, mem_rd_d, cs_n_d, rw_d;
    logic [15:0] mem_addr_d;
    logic [2:0]  address_d;
    logic [7:0]  data_out_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        latch_d = latch_q;
        done_d  = 1'b0;
        if (cpu_ce) begin
            case (state_q)
                IDLE: begin
                    if (reg_wr) begin
                        page_d  = reg_data;
                        idx_d   = 8'h00;
                        state_d = HALT;
                    end
                end
                HALT:  state_d = cpu_odd ? ALIGN : READ;
                ALIGN: state_d = READ;
                READ: begin
                    latch_d = mem_data_in;
                    state_d = WRITE;
                end
                WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they change only on strobe edges.
        active_d   = (state_d != IDLE);
        mem_rd_d   = (state_d == READ);
        mem_addr_d = (state_d == READ) ? {page_d, idx_d} : 16'h0000;
        cs_n_d     = (state_d != WRITE);
        rw_d       = (state_d == WRITE) ? RW_WRITE : RW_READ;
        address_d  = (state_d == WRITE) ? OAMDATA_REG : 3'h0;
        data_out_d = (state_d == WRITE) ? latch_d : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 8'h00;
            page_q       <= 8'h00;
            latch_q      <= 8'h00;
            dma_active   <= 1'b0;
            dma_done     <= 1'b0;
            mem_rd       <= 1'b0;
            mem_addr     <= 16'h0000;
            ppu_cs_n     <= 1'b1;
            ppu_rw       <= RW_READ;
            ppu_address  <= 3'h0;
            ppu_data_out <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            page_q       <= page_d;
            latch_q      <= latch_d;
            dma_active   <= active_d;
            dma_done     <= done_d;
            mem_rd       <= mem_rd_d;
            mem_addr     <= mem_addr_d;
            ppu_cs_n     <= cs_n_d;
            ppu_rw       <= rw_d;
            ppu_address  <= address_d;
            ppu_data_out <= data_out_d;
        end
    end

endmodule
